// File: rtl/conv2d_seq_engine.sv
// Sequential valid-mode 2-D convolution (stride 1, kernel rotated 180 deg) on one MAC.
// Optional CONV2D_SEQ_SAT_EN: saturate results to DATA_W bits instead of truncating.
module conv2d_seq_engine #(
  parameter int DATA_W = 8,
  parameter int IMG    = 4,
  parameter int KER    = 3,
  parameter int ACC_W  = 2*DATA_W + $clog2(KER*KER),
  localparam int O     = IMG - KER + 1,
  localparam int RW    = (O > 1) ? $clog2(O) : 1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       start,
  input  logic [IMG*IMG*DATA_W-1:0]  img_flat,
  input  logic [KER*KER*DATA_W-1:0]  ker_flat,
  output logic                       busy,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [DATA_W-1:0]          out_data,
  output logic [RW-1:0]              out_row,
  output logic [RW-1:0]              out_col,
  output logic                       done
);
  localparam logic [1:0] S_IDLE = 2'd0, S_MAC = 2'd1, S_EMIT = 2'd2, S_DONE = 2'd3;
  localparam int KW = (KER > 1) ? $clog2(KER) : 1;
  localparam int PW = (IMG*IMG > 1) ? $clog2(IMG*IMG) : 1;
  localparam int TW = (KER*KER > 1) ? $clog2(KER*KER) : 1;

  logic [1:0]          state;
  logic [DATA_W-1:0]   img_m [IMG*IMG];
  logic [DATA_W-1:0]   ker_m [KER*KER];
  logic [ACC_W-1:0]    acc, acc_nxt;
  logic [2*DATA_W-1:0] prod;
  logic [KW-1:0]       ki, kj;
  logic [RW-1:0]       row, col;
  logic [PW-1:0]       pix_idx;
  logic [TW-1:0]       tap_idx;
  logic [DATA_W-1:0]   res;

  // Tap index walks the kernel backwards, which gives the 180-degree rotation.
  always_comb begin
    pix_idx = PW'((32'(row) + 32'(ki)) * IMG + 32'(col) + 32'(kj));
    tap_idx = TW'(KER*KER - 1 - (32'(ki) * KER + 32'(kj)));
    prod    = {{DATA_W{1'b0}}, img_m[pix_idx]} * {{DATA_W{1'b0}}, ker_m[tap_idx]};
    acc_nxt = acc + ACC_W'(prod);
`ifdef CONV2D_SEQ_SAT_EN
    res = (acc_nxt > ACC_W'({DATA_W{1'b1}})) ? {DATA_W{1'b1}} : acc_nxt[DATA_W-1:0];
`else
    res = acc_nxt[DATA_W-1:0];
`endif
  end

  // Operand snapshot is plain data storage; only the control path needs reset.
  always_ff @(posedge clk) begin
    if (state == S_IDLE && start) begin
      for (int k = 0; k < IMG*IMG; k++) img_m[k] <= img_flat[k*DATA_W +: DATA_W];
      for (int k = 0; k < KER*KER; k++) ker_m[k] <= ker_flat[k*DATA_W +: DATA_W];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= S_IDLE;
      acc      <= '0;
      ki       <= '0;
      kj       <= '0;
      row      <= '0;
      col      <= '0;
      out_data <= '0;
    end else begin
      case (state)
        S_IDLE: if (start) begin
          acc   <= '0;
          ki    <= '0;
          kj    <= '0;
          row   <= '0;
          col   <= '0;
          state <= S_MAC;
        end
        S_MAC: begin
          acc <= acc_nxt;
          if (kj == KW'(KER-1)) begin
            kj <= '0;
            if (ki == KW'(KER-1)) begin
              ki       <= '0;
              out_data <= res;
              state    <= S_EMIT;
            end else begin
              ki <= ki + KW'(1);
            end
          end else begin
            kj <= kj + KW'(1);
          end
        end
        S_EMIT: if (out_ready) begin
          acc <= '0;
          if (row == RW'(O-1) && col == RW'(O-1)) begin
            state <= S_DONE;
          end else begin
            if (col == RW'(O-1)) begin
              col <= '0;
              row <= row + RW'(1);
            end else begin
              col <= col + RW'(1);
            end
            state <= S_MAC;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign busy      = (state == S_MAC) || (state == S_EMIT);
  assign out_valid = (state == S_EMIT);
  assign done      = (state == S_DONE);
  assign out_row   = row;
  assign out_col   = col;
endmodule
